exec_unit_seq: RTL and testbench

EXEC_UNIT_SEQ -- requirements
Module: exec_unit_seq

---
 rtl/exec_unit_seq.sv | 158 +++++++++++++++
 tb/tb_exec_unit_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_seq.sv
// Integer execute unit: 1-cycle ALU ops, bit-serial shifts (1 + shamt cycles), result held in DONE.
// Backpressure: in_ready only in IDLE; result held stable until out_valid && out_ready; flush aborts.
package exec_unit_pkg;
    typedef enum logic {OP1_REG = 1'b0, OP1_PC  = 1'b1} operand1_sel_t;
    typedef enum logic {OP2_REG = 1'b0, OP2_IMM = 1'b1} operand2_sel_t;

    typedef struct packed {
        logic [3:0]    exec_op;
        operand1_sel_t operand1_sel;
        operand2_sel_t operand2_sel;
    } exec_unit_params;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
endpackage

module exec_unit_seq
    import exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  exec_unit_params params,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_kind_t;

    state_t          state_q, state_d;
    shift_kind_t     shift_kind_q, shift_kind_d;
    logic [4:0]      shift_cnt_q, shift_cnt_d;
    logic [XLEN-1:0] result_d;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_step;
    logic            is_shift;
    shift_kind_t     dec_kind;
    logic            accept;

    assign op1   = (params.operand1_sel == OP1_PC)  ? pc  : rs1_data;
    assign op2   = (params.operand2_sel == OP2_IMM) ? imm : rs2_data;
    assign shamt = op2[4:0];

    // Reset gates in_ready directly so it drops without waiting for an edge.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready && !flush;

    // Single-cycle ops resolve here; shifts seed the result register with op1.
    always_comb begin
        alu_res  = '0;
        is_shift = 1'b0;
        dec_kind = SH_LL;
        case (params.exec_op[2:0])
            F3_ADD:  alu_res = params.exec_op[3] ? (op1 - op2) : (op1 + op2);
            F3_SLL:  begin
                is_shift = 1'b1;
                dec_kind = SH_LL;
                alu_res  = op1;
            end
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            F3_XOR:  alu_res = op1 ^ op2;
            F3_SR:   begin
                is_shift = 1'b1;
                dec_kind = params.exec_op[3] ? SH_RA : SH_RL;
                alu_res  = op1;
            end
            F3_OR:   alu_res = op1 | op2;
            F3_AND:  alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shift_step = result;
        case (shift_kind_q)
            SH_LL:   shift_step = {result[XLEN-2:0], 1'b0};
            SH_RL:   shift_step = {1'b0, result[XLEN-1:1]};
            SH_RA:   shift_step = {result[XLEN-1], result[XLEN-1:1]};
            default: shift_step = result;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shift_kind_d = shift_kind_q;
        shift_cnt_d  = shift_cnt_q;
        result_d     = result;
        if (flush) begin
            state_d     = IDLE;
            shift_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        result_d     = alu_res;
                        shift_kind_d = dec_kind;
                        if (is_shift && (shamt != 5'd0)) begin
                            state_d     = SHIFT;
                            shift_cnt_d = shamt;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SHIFT: begin
                    result_d    = shift_step;
                    shift_cnt_d = shift_cnt_q - 5'd1;
                    if (shift_cnt_q == 5'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_kind_q <= SH_LL;
            shift_cnt_q  <= '0;
            result       <= '0;
        end else begin
            state_q      <= state_d;
            shift_kind_q <= shift_kind_d;
            shift_cnt_q  <= shift_cnt_d;
            result       <= result_d;
        end
    end

endmodule

// File: tb/tb_exec_unit_seq.sv
// Randomized scoreboard bench for exec_unit_seq: driver pushes expected results and due cycles,
// a negedge monitor pops and compares on every DUT handshake.
module tb_exec_unit_seq;
    import exec_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    exec_unit_params params;
    logic [XLEN-1:0] rs1_data, rs2_data, pc, imm;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;
    exp_t sb[$];
    bit   seen = 1'b0;

    bit rdy_force_en  = 1'b1;
    bit rdy_force_val = 1'b1;

    exec_unit_seq #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .params   (params),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .pc       (pc),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        out_ready = rdy_force_en ? rdy_force_val : ($urandom_range(0, 9) < 7);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural meaning of each op, shifts done in one go.
    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op[2:0])
            3'b000:  return op[3] ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return op[3] ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op[2:0] == 3'b001 || op[2:0] == 3'b101) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    task automatic scramble();
        rs1_data = $urandom;
        rs2_data = $urandom;
        pc       = $urandom;
        imm      = $urandom;
        params.exec_op      = 4'($urandom);
        params.operand1_sel = operand1_sel_t'(1'($urandom));
        params.operand2_sel = operand2_sel_t'(1'($urandom));
    endtask

    // Starts and ends on a posedge; returns right after the accepting edge.
    task automatic issue(input logic [3:0] op, input operand1_sel_t s1, input operand2_sel_t s2,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p, input logic [31:0] im);
        logic [31:0] a, b;
        bit r, f, ok;
        int n;
        #1;
        params.exec_op      = op;
        params.operand1_sel = s1;
        params.operand2_sel = s2;
        rs1_data = r1;
        rs2_data = r2;
        pc       = p;
        imm      = im;
        in_valid = 1'b1;
        a  = (s1 == OP1_PC)  ? p  : r1;
        b  = (s2 == OP2_IMM) ? im : r2;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            r = in_ready;
            f = flush;
            n = cyc;
            @(posedge clk);
            if (r && !f) ok = 1'b1;
            else #1;
        end
        if (ok) begin
            sb.push_back('{res: ref_res(op, a, b), due: n + ref_lat(op, b)});
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: op %0h never accepted", op);
        end
    endtask

    task automatic hold();
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n;
        hold();
        @(posedge clk);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (reset || flush) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: result %0h with nothing outstanding", result);
            end else begin
                if (!seen) begin
                    chk("latency", 64'(cyc), 64'(sb[0].due));
                    seen = 1'b1;
                end
                chk("result", 64'(result), 64'(sb[0].res));
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        scramble();
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("post_reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);

        issue(4'b0000, OP1_REG, OP2_IMM, 32'hFFFF_FFFF, $urandom, $urandom, 32'd1);
        drain();

        issue(4'b1101, OP1_REG, OP2_IMM, 32'h8000_0000, $urandom, $urandom, 32'd4);
        for (int k = 1; k <= 5; k++) begin
            hold();
            chk("sra_busy_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
        end
        drain();

        issue(4'b1000, OP1_PC, OP2_REG, $urandom, 32'h104, 32'h100, $urandom);
        issue(4'b0011, OP1_PC, OP2_REG, $urandom, 32'h104, 32'h100, $urandom);
        issue(4'b0010, OP1_REG, OP2_IMM, 32'hFFFF_FFFF, $urandom, $urandom, 32'd1);
        drain();

        rdy_force_val = 1'b0;
        issue(4'b0000, OP1_REG, OP2_REG, 32'd5, 32'd7, $urandom, $urandom);
        for (int k = 0; k < 3; k++) begin
            hold();
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_result", 64'(result), 64'(12));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
        end
        rdy_force_val = 1'b1;
        hold();
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'(1));
        chk("bp_release_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);

        #1;
        scramble();
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_blocks_accept", 64'(in_ready), 64'(1));
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("flush_idle_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);

        issue(4'b0001, OP1_REG, OP2_IMM, $urandom, $urandom, $urandom, 32'd31);
        for (int j = 1; j <= 9; j++) begin
            hold();
            chk("sll_shift_out_valid", 64'(out_valid), 64'(0));
            @(posedge clk);
        end
        #1;
        flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_shift_in_ready", 64'(in_ready), 64'(1));
        chk("flush_shift_out_valid", 64'(out_valid), 64'(0));
        repeat (30) begin
            @(posedge clk);
            #1 chk("flushed_no_output", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        issue(4'b0000, OP1_REG, OP2_REG, $urandom, $urandom, $urandom, $urandom);
        drain();

        rdy_force_val = 1'b0;
        issue(4'b0100, OP1_REG, OP2_REG, $urandom, $urandom, $urandom, $urandom);
        #1;
        in_valid = 1'b0;
        flush    = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_done_out_valid", 64'(out_valid), 64'(0));
        chk("flush_done_in_ready", 64'(in_ready), 64'(1));
        rdy_force_val = 1'b1;
        @(posedge clk);

        issue(4'b0101, OP1_REG, OP2_IMM, $urandom, $urandom, $urandom, 32'd20);
        repeat (3) begin
            hold();
            @(posedge clk);
        end
        #3;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mid_result", 64'(result), 64'(0));
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("rst_release_in_ready", 64'(in_ready), 64'(1));
        repeat (25) begin
            @(posedge clk);
            #1 chk("rst_no_stale_output", 64'(out_valid), 64'(0));
        end
        @(posedge clk);

        rdy_force_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] b2, bi;
            r1 = $urandom;
            b2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            bi = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            issue(4'($urandom), operand1_sel_t'(1'($urandom)), operand2_sel_t'(1'($urandom)),
                  r1, b2, $urandom, bi);
            repeat ($urandom_range(0, 2)) begin
                hold();
                @(posedge clk);
            end
        end
        rdy_force_en  = 1'b1;
        rdy_force_val = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
